// File: rtl/ifetch_rom.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_rom
// Purpose  : Byte-serial instruction fetch from a synchronous 8-bit ROM,
//            assembling little-endian 32-bit instructions for decode.
// Revision : 1.0
// ============================================================================
module ifetch_rom #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_LAT  = 1,
    parameter int          ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [7:0]        rom_q,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc
);

    localparam logic [1:0]  c_FETCH = 2'd0;
    localparam logic [1:0]  c_WAIT  = 2'd1;
    localparam logic [1:0]  c_HOLD  = 2'd2;
    localparam logic [31:0] c_RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [1:0]  r_issue_cnt;
    logic [23:0] r_buf;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_inst_valid;
    // Tag pipe entry: {valid, byte index}; entry ROM_LAT-1 lines up with rom_q.
    logic [2:0]  r_tag [ROM_LAT];

    logic        w_issue;
    logic [2:0]  w_tag_in;
    logic [2:0]  w_tag_out;
    logic        w_cap;
    logic [1:0]  w_cap_idx;

    assign w_issue   = (r_state == c_FETCH) && en;
    assign w_tag_in  = {w_issue, r_issue_cnt};
    assign w_tag_out = r_tag[ROM_LAT-1];
    assign w_cap     = w_tag_out[2];
    assign w_cap_idx = w_tag_out[1:0];

    assign rom_address = rst_n ? (r_pc[ADDR_W-1:0] + ADDR_W'(r_issue_cnt))
                               : c_RESET_PC_AL[ADDR_W-1:0];
    assign inst_valid  = r_inst_valid;
    assign inst        = r_inst;
    assign inst_pc     = r_inst_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_FETCH;
            r_pc         <= c_RESET_PC_AL;
            r_issue_cnt  <= 2'd0;
            r_buf        <= 24'd0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
            r_inst_valid <= 1'b0;
            for (int i = 0; i < ROM_LAT; i++) begin
                r_tag[i] <= 3'd0;
            end
        end else if (redirect_valid) begin
            // Flushing the tag pipe drops every read issued up to this edge.
            r_state      <= c_FETCH;
            r_pc         <= {redirect_pc[31:2], 2'b00};
            r_issue_cnt  <= 2'd0;
            r_buf        <= 24'd0;
            r_inst_valid <= 1'b0;
            for (int i = 0; i < ROM_LAT; i++) begin
                r_tag[i] <= 3'd0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end

            case (r_state)
                c_FETCH: begin
                    if (en) begin
                        if (r_issue_cnt == 2'd3) begin
                            r_state <= c_WAIT;
                        end else begin
                            r_issue_cnt <= r_issue_cnt + 2'd1;
                        end
                    end
                end
                c_WAIT: begin
                end
                c_HOLD: begin
                    if (inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_pc         <= r_pc + 32'd4;
                        r_issue_cnt  <= 2'd0;
                        r_state      <= c_FETCH;
                    end
                end
                default: r_state <= c_FETCH;
            endcase

            // The last byte only ever arrives in WAIT, so this cannot collide with HOLD.
            if (w_cap) begin
                case (w_cap_idx)
                    2'd0: r_buf[7:0]   <= rom_q;
                    2'd1: r_buf[15:8]  <= rom_q;
                    2'd2: r_buf[23:16] <= rom_q;
                    default: begin
                        r_inst       <= {rom_q, r_buf};
                        r_inst_pc    <= r_pc;
                        r_inst_valid <= 1'b1;
                        r_state      <= c_HOLD;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_rom.sv
`default_nettype none
// Testbench for ifetch_rom: two instances (RESET_PC 0/ROM_LAT 1 and
// RESET_PC 0xFC/ROM_LAT 2) share stimulus; a reference model feeds a scoreboard.
module tb_ifetch_rom;

    localparam logic [31:0] RP0 = 32'h0000_0000;
    localparam logic [31:0] RP1 = 32'h0000_00FC;
    localparam int          L0  = 1;
    localparam int          L1  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic [7:0]  rom_address [2];
    logic [7:0]  rom_q       [2];
    logic        inst_valid  [2];
    logic [31:0] inst        [2];
    logic [31:0] inst_pc     [2];

    always #5 clk = ~clk;

    ifetch_rom #(.RESET_PC(RP0), .ROM_LAT(L0), .ADDR_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rom_address(rom_address[0]), .rom_q(rom_q[0]),
        .inst_valid(inst_valid[0]), .inst_ready(inst_ready),
        .inst(inst[0]), .inst_pc(inst_pc[0])
    );

    ifetch_rom #(.RESET_PC(RP1), .ROM_LAT(L1), .ADDR_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rom_address(rom_address[1]), .rom_q(rom_q[1]),
        .inst_valid(inst_valid[1]), .inst_ready(inst_ready),
        .inst(inst[1]), .inst_pc(inst_pc[1])
    );

    // Synchronous ROMs with one and two edges of latency.
    logic [7:0] rom [256];
    logic [7:0] rom_d1;
    always @(posedge clk) begin
        rom_q[0] <= rom[rom_address[0]];
        rom_d1   <= rom[rom_address[1]];
        rom_q[1] <= rom_d1;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] m_pc        [2];
    int          m_reads     [2];
    int          m_due       [2];
    bit          m_exp_valid [2];
    bit          m_rst_edge  [2];
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];

    function automatic logic [31:0] word(input logic [31:0] pc);
        logic [7:0] a;
        a = pc[7:0];
        return {rom[a + 8'd3], rom[a + 8'd2], rom[a + 8'd1], rom[a]};
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? L0 : L1;
    endfunction

    task automatic restart(input int k, input logic [31:0] pc);
        m_pc[k]        = pc;
        m_reads[k]     = 0;
        m_exp_valid[k] = 1'b0;
        if (k == 0) begin
            q0.delete();
            q0.push_back({pc, word(pc)});
        end else begin
            q1.delete();
            q1.push_back({pc, word(pc)});
        end
    endtask

    // Reference model: an instruction needs four enabled fetch cycles, then
    // ROM_LAT more edges; it is held until accepted.
    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            m_rst_edge[k] = !rst_n;
            if (!rst_n) begin
                restart(k, (k == 0) ? RP0 : RP1);
            end else if (redirect_valid) begin
                restart(k, {redirect_pc[31:2], 2'b00});
            end else if (m_exp_valid[k]) begin
                if (inst_ready) restart(k, m_pc[k] + 32'd4);
            end else if (m_reads[k] == 4) begin
                if (cyc == m_due[k]) m_exp_valid[k] = 1'b1;
            end else if (en) begin
                m_reads[k]++;
                if (m_reads[k] == 4) m_due[k] = cyc + lat_of(k);
            end
        end
    end

    bit          have_cur [2];
    logic [63:0] cur      [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (inst_valid[k] !== m_exp_valid[k]) begin
                errors++;
                $display("FAIL dut%0d valid cyc %0d got %0b exp %0b", k, cyc, inst_valid[k], m_exp_valid[k]);
            end
            if (m_rst_edge[k]) begin
                checks++;
                if (inst[k] !== 32'd0 || inst_pc[k] !== 32'd0) begin
                    errors++;
                    $display("FAIL dut%0d reset_outputs got inst %h pc %h exp 0 0", k, inst[k], inst_pc[k]);
                end
                if (!rst_n) begin
                    checks++;
                    if (rom_address[k] !== ((k == 0) ? RP0[7:0] : RP1[7:0])) begin
                        errors++;
                        $display("FAIL dut%0d reset_addr got %h exp %h", k, rom_address[k],
                                 (k == 0) ? RP0[7:0] : RP1[7:0]);
                    end
                end
            end
            if (inst_valid[k] === 1'b1) begin
                if (!have_cur[k]) begin
                    have_cur[k] = 1'b1;
                    if (k == 0 && q0.size() > 0)      cur[k] = q0.pop_front();
                    else if (k == 1 && q1.size() > 0) cur[k] = q1.pop_front();
                    else begin
                        cur[k] = '1;
                        checks++;
                        errors++;
                        $display("FAIL dut%0d unexpected_inst got pc %h exp none", k, inst_pc[k]);
                    end
                end
                checks++;
                if ({inst_pc[k], inst[k]} !== cur[k]) begin
                    errors++;
                    $display("FAIL dut%0d inst cyc %0d got pc %h inst %h exp pc %h inst %h",
                             k, cyc, inst_pc[k], inst[k], cur[k][63:32], cur[k][31:0]);
                end
            end else begin
                have_cur[k] = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic bit cond(input int kind);
        case (kind)
            0:       return m_exp_valid[0];
            1:       return (m_reads[0] == 1) && !m_exp_valid[0];
            2:       return (m_reads[0] == 2) && !m_exp_valid[0];
            default: return (m_reads[0] == 4) && !m_exp_valid[0];
        endcase
    endfunction

    task automatic wait_for(input int kind);
        int n;
        n = 0;
        while (!cond(kind) && n < 40) begin
            step();
            n++;
        end
        if (n == 40) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout kind %0d got timeout exp condition", kind);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h13; rom[1] = 8'h05; rom[2] = 8'h10; rom[3] = 8'h00;
        rst_n = 1'b0; en = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (30) step();

        // Downstream stall while an instruction is held.
        inst_ready = 1'b0;
        wait_for(0);
        repeat (10) step();
        inst_ready = 1'b1;
        step();

        // Redirect mid-fetch to a misaligned target.
        wait_for(2);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0042;
        step();
        redirect_valid = 1'b0;

        // Redirect coinciding with a handshake.
        inst_ready = 1'b0;
        wait_for(0);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0080; inst_ready = 1'b1;
        step();
        redirect_valid = 1'b0;

        // Fetch enable gap, then reset while waiting on outstanding data.
        wait_for(1);
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        wait_for(0);
        step();
        wait_for(3);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (12) step();

        for (int i = 0; i < 600; i++) begin
            en             = ($urandom_range(3, 0) != 0);
            inst_ready     = ($urandom_range(1, 0) == 1);
            redirect_valid = ($urandom_range(15, 0) == 0);
            redirect_pc    = $urandom;
            rst_n          = ($urandom_range(127, 0) != 0);
            step();
        end
        rst_n = 1'b1; en = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
